sar_search_ctrl: RTL and testbench
==================================

SAR_SEARCH_CTRL -- requirements
Module: sar_search_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; clk and rst are the clock and reset ports, all state updates on clk rising edge.
REQ-002 Parameter: WIDTH, 4, bit width of the searched value and the trial comparand (legal 2..16).
REQ-003 Port: clk  input  1  clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request a new search; sampled only in IDLE.
REQ-006 Port: guess  output  WIDTH  trial comparand driven to the external magnitude comparator (b operand).
REQ-007 Port: gt  input  1  comparator result, unknown value a > guess.
REQ-008 Port: eq  input  1  comparator result, a == guess.
REQ-009 Port: lt  input  1  comparator result, a < guess.
REQ-010 Port: busy  output  1  high while a search is in progress.
REQ-011 Port: done  output  1  one-cycle pulse when a search ends.
REQ-012 Port: result  output  WIDTH  recovered value of a; valid from done until the next accepted start.
REQ-013 Port: err  output  1  set with done when comparator inputs were not one-hot; held until the next accepted start.

Function
REQ-014 States: IDLE, TRIAL, DONE; IDLE->TRIAL on start, TRIAL->DONE after the last trial or an early exit or an error, DONE->IDLE unconditionally after one cycle.
REQ-015 On accepting start: bit index = WIDTH-1, accumulator = 0, result = 0, err = 0.
REQ-016 In TRIAL, guess = accumulator OR (1 << bit index); comparator is combinational, so gt/eq/lt are sampled in the same cycle guess is driven.
REQ-017 Trial update: gt or eq -> keep the trial bit in the accumulator; lt -> clear it; then decrement the bit index.
REQ-018 Trial with bit index 0 is the last; result = updated accumulator, state -> DONE.
REQ-019 {gt,eq,lt} not exactly one-hot in any TRIAL cycle -> abort: result = 0, err = 1, state -> DONE.
REQ-020 guess = 0 in IDLE and DONE; busy = 1 only in TRIAL; done = 1 only in DONE.
REQ-021 Latency: start sampled at cycle 0 -> trials at cycles 1..WIDTH -> done at cycle WIDTH+1 (no early exit).
REQ-022 start asserted in TRIAL or DONE is ignored, never queued; start held high re-triggers only once the block is back in IDLE.
REQ-023 Arithmetic: no carry or overflow; all values unsigned WIDTH bits; a = 0 and a = 2^WIDTH-1 are recovered exactly.

Reset
REQ-024 rst forces IDLE, guess = 0, busy = 0, done = 0, result = 0, err = 0, accumulator and bit index = 0, on the next clk edge, including mid-search; no done pulse is produced for an aborted search.
REQ-025 rst has priority over start in the same cycle.

Configuration
REQ-026 Macro SAR_EARLY_EXIT_EN defined: eq in a TRIAL cycle ends the search immediately, result = current guess, done on the following cycle (latency k+1 for exit at trial k).
REQ-027 SAR_EARLY_EXIT_EN undefined: eq is treated as keep-bit only; every search takes exactly WIDTH trials.

Structure
REQ-028 Shared package sar_pkg SHALL hold the state enum (IDLE, TRIAL, DONE) and a one-hot check function for the 3-bit comparator result.
REQ-029 No sub-module in RTL; the bench instantiates the team's 2-bit/4-bit magnitude comparator model as the responder, fed by guess and the unknown a.

Verification (WIDTH = 4, cycle 0 = start sampled)
REQ-030 a = 11, early exit on: guesses 8(gt), 12(lt), 10(gt), 11(eq) -> done at cycle 5, result = 11, err = 0.
REQ-031 a = 8: early exit on -> eq at trial 1, done at cycle 2, result = 8; early exit off -> guesses 8, 12, 10, 9, done at cycle 5, result = 8.
REQ-032 a = 0 -> guesses 8, 4, 2, 1 all lt, done at cycle 5, result = 0; a = 15 -> guesses 8, 12, 14, 15, result = 15.
REQ-033 Force gt = eq = 1 at trial 2 -> done at cycle 3, err = 1, result = 0; next start clears err.
REQ-034 rst at cycle 2 of a search -> cycle 3 shows IDLE with all outputs 0 and no done pulse; start pulsed during TRIAL has no effect on the running search.

Source files
------------

// File: rtl/sar_pkg.sv
// sar_pkg: FSM states and comparator one-hot check shared by the SAR search controller
package sar_pkg;
  typedef enum logic [1:0] {IDLE, TRIAL, DONE} state_t;
  function automatic logic onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction
endpackage

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: MSB-first successive-approximation search over an external comparator; SAR_EARLY_EXIT_EN ends a search on eq
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             gt,
  input  logic             eq,
  input  logic             lt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);
  localparam int IW = $clog2(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] acc, acc_n, acc_upd, result_n;
  logic [IW-1:0] idx, idx_n;
  logic err_n, early;
`ifdef SAR_EARLY_EXIT_EN
  assign early = eq;
`else
  assign early = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      idx    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      idx    <= idx_n;
      result <= result_n;
      err    <= err_n;
    end
  end
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    idx_n    = idx;
    result_n = result;
    err_n    = err;
    guess    = '0;
    acc_upd  = acc;
    case (state)
      IDLE: if (start) begin
        state_n  = TRIAL;
        idx_n    = IW'(WIDTH - 1);
        acc_n    = '0;
        result_n = '0;
        err_n    = 1'b0;
      end
      TRIAL: begin
        guess   = acc | (WIDTH'(1) << idx);
        acc_upd = lt ? acc : guess;
        if (!onehot3({gt, eq, lt})) begin
          state_n  = DONE;
          result_n = '0;
          err_n    = 1'b1;
        end else if (early) begin
          state_n  = DONE;
          result_n = guess;
        end else if (idx == '0) begin
          state_n  = DONE;
          result_n = acc_upd;
        end else begin
          acc_n = acc_upd;
          idx_n = idx - IW'(1);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign busy = (state == TRIAL);
  assign done = (state == DONE);
endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: directed vector table plus error, reset and start-ignore sequences
module tb_sar_search_ctrl;
  logic clk = 0, rst = 1, start = 0;
  logic [3:0] guess, result, a_val = 0;
  logic gt, eq, lt, busy, done, err;
  logic force_bad = 0;
  int pass = 0, total = 0;

  sar_search_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .guess(guess),
    .gt(gt), .eq(eq), .lt(lt),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  assign gt = force_bad ? 1'b1 : (a_val > guess);
  assign eq = force_bad ? 1'b1 : (a_val == guess);
  assign lt = force_bad ? 1'b0 : (a_val < guess);

  typedef struct {
    logic [3:0]       a;
    logic [0:3][3:0]  g;
    int               n;
    logic [3:0]       res;
    logic             hold;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v);
    @(negedge clk);
    a_val = v.a;
    start = 1;
    tick();
    if (!v.hold) start = 0;
    for (int k = 0; k < v.n; k++) begin
      check("busy_trial", busy, 1);
      check("done_trial", done, 0);
      check("guess", guess, v.g[k]);
      if (k == 0) check("result_cleared", result, 0);
      tick();
    end
    start = 0;
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("guess_done", guess, 0);
    check("result", result, v.res);
    check("err", err, 0);
    tick();
    check("done_low", done, 0);
    check("busy_idle", busy, 0);
    check("result_held", result, v.res);
  endtask

  initial begin
`ifdef SAR_EARLY_EXIT_EN
    vecs[0] = '{4'd11, {4'd8, 4'd12, 4'd10, 4'd11}, 4, 4'd11, 1'b0};
    vecs[1] = '{4'd8,  {4'd8, 4'd0,  4'd0,  4'd0},  1, 4'd8,  1'b0};
    vecs[2] = '{4'd0,  {4'd8, 4'd4,  4'd2,  4'd1},  4, 4'd0,  1'b0};
    vecs[3] = '{4'd15, {4'd8, 4'd12, 4'd14, 4'd15}, 4, 4'd15, 1'b0};
    vecs[4] = '{4'd5,  {4'd8, 4'd4,  4'd6,  4'd5},  4, 4'd5,  1'b1};
`else
    vecs[0] = '{4'd11, {4'd8, 4'd12, 4'd10, 4'd11}, 4, 4'd11, 1'b0};
    vecs[1] = '{4'd8,  {4'd8, 4'd12, 4'd10, 4'd9},  4, 4'd8,  1'b0};
    vecs[2] = '{4'd0,  {4'd8, 4'd4,  4'd2,  4'd1},  4, 4'd0,  1'b0};
    vecs[3] = '{4'd15, {4'd8, 4'd12, 4'd14, 4'd15}, 4, 4'd15, 1'b0};
    vecs[4] = '{4'd5,  {4'd8, 4'd4,  4'd6,  4'd5},  4, 4'd5,  1'b1};
`endif
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_guess", guess, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) run(vecs[i]);

    // comparator forced to gt=eq=1 on the second trial
    @(negedge clk);
    a_val = 4'd11;
    start = 1;
    tick();
    start = 0;
    check("err_seq_guess1", guess, 8);
    tick();
    check("err_seq_guess2", guess, 12);
    force_bad = 1;
    tick();
    force_bad = 0;
    check("err_done", done, 1);
    check("err_flag", err, 1);
    check("err_result", result, 0);
    tick();
    check("err_held", err, 1);
    check("err_done_low", done, 0);
    @(negedge clk);
    a_val = 4'd3;
    start = 1;
    tick();
    start = 0;
    check("err_cleared", err, 0);
    check("err_restart_busy", busy, 1);
    begin
      int cyc = 0;
      while (!done && cyc < 20) begin
        tick();
        cyc++;
      end
      check("restart_done_seen", done, 1);
      check("restart_result", result, 3);
      check("restart_err", err, 0);
    end
    tick();

    // reset two cycles into a search
    @(negedge clk);
    a_val = 4'd6;
    start = 1;
    tick();
    start = 0;
    tick();
    check("pre_rst_busy", busy, 1);
    rst = 1;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_guess", guess, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_err", err, 0);
    @(negedge clk);
    rst = 0;
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (done) seen++;
      end
      check("no_done_after_rst", seen, 0);
    end

    // rst wins over start in the same cycle
    @(negedge clk);
    rst = 1;
    start = 1;
    tick();
    check("rst_priority_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    start = 0;
    tick();
    check("rst_priority_idle", busy, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
